// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed/unsigned divider: FSM state
// encoding, reused by the divider core, debug viewers and the bench.
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_sgn_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  // Compare at WIDTH+1 bits so a partial remainder with its top bit set is
  // never truncated before the comparison.
  always_comb begin
    shifted = {rem_i, msb_i};
    q_o     = 1'b0;
    rem_o   = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, divisor_i}) begin
      q_o   = 1'b1;
      rem_o = shifted[WIDTH-1:0] - divisor_i;
    end
  end

endmodule

// File: rtl/seq_divider_sgn.sv
// Multi-cycle radix-2 restoring divider with per-operation signed/unsigned
// mode, divide-by-zero and signed-overflow flags, busy/valid handshake.
module seq_divider_sgn
  import divider_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             SIGNED_IN,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic [WIDTH-1:0] Q_OUT,
  output logic [WIDTH-1:0] R_OUT,
  output logic             valid,
  output logic             busy,
  output logic             DIV0,
  output logic             OVF,
  output logic [1:0]       STATE_OUT,
  output logic [CNT_W-1:0] COUNT_OUT
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             ovf_pend_q;
  logic [WIDTH-1:0] q_out_q;
  logic [WIDTH-1:0] r_out_q;
  logic             valid_q;
  logic             busy_q;
  logic             div0_q;
  logic             ovf_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             ovf_case;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes and sign bookkeeping for the start of an operation.
  always_comb begin
    a_neg    = SIGNED_IN & A_IN[WIDTH-1];
    b_neg    = SIGNED_IN & B_IN[WIDTH-1];
    a_mag    = a_neg ? ('0 - A_IN) : A_IN;
    b_mag    = b_neg ? ('0 - B_IN) : B_IN;
    ovf_case = SIGNED_IN && (A_IN == {1'b1, {(WIDTH-1){1'b0}}}) && (B_IN == '1);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Sign restoration of the unsigned result. MIN / -1 yields |MIN| = MIN,
  // whose negation wraps back to MIN with zero remainder.
  always_comb begin
    q_fix = qneg_q ? ('0 - dvd_q) : dvd_q;
    r_fix = rneg_q ? ('0 - rem_q) : rem_q;
  end

  // Control FSM, iteration counter and registered result/flag outputs.
  // The quotient bits shift into the low end of the dividend register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            if (B_IN == '0) begin
              q_out_q <= '1;
              r_out_q <= A_IN;
              div0_q  <= 1'b1;
              ovf_q   <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              dvd_q      <= a_mag;
              dvs_q      <= b_mag;
              rem_q      <= '0;
              cnt_q      <= '0;
              qneg_q     <= a_neg ^ b_neg;
              rneg_q     <= a_neg;
              ovf_pend_q <= ovf_case;
              busy_q     <= 1'b1;
              state_q    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          q_out_q <= q_fix;
          r_out_q <= r_fix;
          div0_q  <= 1'b0;
          ovf_q   <= ovf_pend_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Q_OUT     = q_out_q;
  assign R_OUT     = r_out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign DIV0      = div0_q;
  assign OVF       = ovf_q;
  assign STATE_OUT = state_q;
  assign COUNT_OUT = cnt_q;

endmodule

// File: tb/tb_seq_divider_sgn.sv
// Directed self-checking bench for seq_divider_sgn (WIDTH=8).
module tb_seq_divider_sgn;
  import divider_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       SIGNED_IN;
  logic [7:0] A_IN;
  logic [7:0] B_IN;
  logic [7:0] Q_OUT;
  logic [7:0] R_OUT;
  logic       valid;
  logic       busy;
  logic       DIV0;
  logic       OVF;
  logic [1:0] STATE_OUT;
  logic [2:0] COUNT_OUT;

  int checks   = 0;
  int failures = 0;

  seq_divider_sgn #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .SIGNED_IN (SIGNED_IN),
    .A_IN      (A_IN),
    .B_IN      (B_IN),
    .Q_OUT     (Q_OUT),
    .R_OUT     (R_OUT),
    .valid     (valid),
    .busy      (busy),
    .DIV0      (DIV0),
    .OVF       (OVF),
    .STATE_OUT (STATE_OUT),
    .COUNT_OUT (COUNT_OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge that is lat=1 cycles past the accepting edge;
  // advances until valid is seen, counting busy cycles on the way.
  task automatic wait_valid(output int lat, output int busyc);
    lat   = 1;
    busyc = 0;
    while (valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ed0,
                        input logic eovf, input int elat, input int ebusy);
    int lat;
    int busyc;
    @(negedge clk);
    SIGNED_IN = s; A_IN = a; B_IN = b; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_valid(lat, busyc);
    check({tag, ".lat"},   lat,   elat);
    check({tag, ".busyc"}, busyc, ebusy);
    check({tag, ".Q"},     Q_OUT, eq);
    check({tag, ".R"},     R_OUT, er);
    check({tag, ".DIV0"},  DIV0,  ed0);
    check({tag, ".OVF"},   OVF,   eovf);
    check({tag, ".busy"},  busy,  1'b0);
    @(negedge clk);
    check({tag, ".pulse"}, valid, 1'b0);
    check({tag, ".hold"},  Q_OUT, eq);
  endtask

  initial begin
    int lat;
    int busyc;
    int n;
    logic saw_valid;

    rst = 1'b0; en = 1'b0; SIGNED_IN = 1'b0; A_IN = '0; B_IN = '0;
    #1;
    check("rst.Q",     Q_OUT,     8'h00);
    check("rst.R",     R_OUT,     8'h00);
    check("rst.valid", valid,     1'b0);
    check("rst.busy",  busy,      1'b0);
    check("rst.DIV0",  DIV0,      1'b0);
    check("rst.OVF",   OVF,       1'b0);
    check("rst.state", STATE_OUT, 2'd0);
    check("rst.count", COUNT_OUT, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("u100_7",   1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 10, 9);
    run_op("s-100_7",  1'b1, 8'h9C,  8'h07, 8'hF2,  8'hFE, 1'b0, 1'b0, 10, 9);
    run_op("s100_-7",  1'b1, 8'h64,  8'hF9, 8'hF2,  8'h02, 1'b0, 1'b0, 10, 9);
    run_op("s-7_-2",   1'b1, 8'hF9,  8'hFE, 8'h03,  8'hFF, 1'b0, 1'b0, 10, 9);
    run_op("u12_0",    1'b0, 8'd12,  8'd0,  8'hFF,  8'd12, 1'b1, 1'b0, 1,  0);
    run_op("s-16_0",   1'b1, 8'hF0,  8'h00, 8'hFF,  8'hF0, 1'b1, 1'b0, 1,  0);
    run_op("sMIN_-1",  1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1, 10, 9);
    run_op("u128_255", 1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0, 10, 9);
    run_op("u255_1",   1'b0, 8'hFF,  8'h01, 8'hFF,  8'h00, 1'b0, 1'b0, 10, 9);

    // en while busy is dropped; en at the FIX edge is dropped; en held into
    // the valid cycle starts the next operation.
    @(negedge clk);
    SIGNED_IN = 1'b0; A_IN = 8'd200; B_IN = 8'd3; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    A_IN = 8'd50; B_IN = 8'd5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 0;
    while (STATE_OUT !== S_FIX && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busyen.reachfix", STATE_OUT, S_FIX);
    A_IN = 8'd50; B_IN = 8'd5; en = 1'b1;
    @(negedge clk);
    check("busyen.valid", valid, 1'b1);
    check("busyen.Q",     Q_OUT, 8'd66);
    check("busyen.R",     R_OUT, 8'd2);
    @(negedge clk);
    en = 1'b0;
    check("b2b.busy", busy, 1'b1);
    wait_valid(lat, busyc);
    check("b2b.lat", lat,   10);
    check("b2b.Q",   Q_OUT, 8'd10);
    check("b2b.R",   R_OUT, 8'd0);

    // Asynchronous reset in the middle of CALC aborts without a result.
    @(negedge clk);
    SIGNED_IN = 1'b0; A_IN = 8'd200; B_IN = 8'd3; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.midcalc", STATE_OUT, S_CALC);
    #2 rst = 1'b0;
    #1;
    check("abort.Q",     Q_OUT,     8'h00);
    check("abort.R",     R_OUT,     8'h00);
    check("abort.busy",  busy,      1'b0);
    check("abort.valid", valid,     1'b0);
    check("abort.state", STATE_OUT, 2'd0);
    check("abort.count", COUNT_OUT, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    check("abort.novalid", saw_valid, 1'b0);
    run_op("u9_4", 1'b0, 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0, 10, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
